sram22_req_adapter: RTL and testbench

//  Upstream front-end for a single-port SRAM22 macro (clk/we/wmask/addr/din/dout, 1-cycle read).

---
 rtl/sram22_pkg.sv | 21 ++
 rtl/sram22_rsp_fifo.sv | 49 ++++
 rtl/sram22_req_adapter.sv | 98 +++++++++
 tb/tb_sram22_req_adapter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram22_pkg.sv
// Shared constants and request/response bundle types for the SRAM22 front-end.
// The typedefs describe the default macro geometry.
package sram22_pkg;

  localparam int SRAM22_DATA_W  = 32;
  localparam int SRAM22_ADDR_W  = 9;
  localparam int SRAM22_WMASK_W = 4;

  typedef struct packed {
    logic                      we;
    logic [SRAM22_WMASK_W-1:0] wmask;
    logic [SRAM22_ADDR_W-1:0]  addr;
    logic [SRAM22_DATA_W-1:0]  wdata;
  } sram22_req_t;

  typedef struct packed {
    logic                     is_write;
    logic [SRAM22_DATA_W-1:0] rdata;
  } sram22_rsp_t;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Synchronous response FIFO with registered storage, exposing count, push, pop and head.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module sram22_rsp_fifo
  import sram22_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = SRAM22_DATA_W,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage carries data only; validity lives in r_count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/sram22_req_adapter.sv
// Valid/ready front-end for a single-port SRAM22 macro with credit-guarded response FIFO.
// Optional SRAM22_WRITE_ACK_EN: writes return an ack entry {is_write=1, rdata=0}.
module sram22_req_adapter
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH  = SRAM22_DATA_W,
  parameter int ADDR_WIDTH  = SRAM22_ADDR_W,
  parameter int WMASK_WIDTH = SRAM22_WMASK_W,
  parameter int RSP_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   rsp_is_write,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
`ifdef SRAM22_WRITE_ACK_EN
  localparam int RSP_W = DATA_WIDTH + 1;
`else
  localparam int RSP_W = DATA_WIDTH;
`endif

  logic             w_req_fire;
  logic             w_rsp_fire;
  logic             w_pend;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_used;
  logic [RSP_W-1:0] w_push_data;
  logic [RSP_W-1:0] w_head;
  logic             r_rd_pend_p1;

  assign w_req_fire = req_valid & req_ready;
  assign w_rsp_fire = rsp_valid & rsp_ready;

  assign sram_we    = w_req_fire & req_we;
  assign sram_wmask = req_wmask;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;

  // Stage p0 -> p1: macro issue; dout is valid the cycle after a read fire.
  always_ff @(posedge clk) begin
    if (!rst_n) r_rd_pend_p1 <= 1'b0;
    else        r_rd_pend_p1 <= w_req_fire & ~req_we;
  end

`ifdef SRAM22_WRITE_ACK_EN
  logic r_wr_pend_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) r_wr_pend_p1 <= 1'b0;
    else        r_wr_pend_p1 <= w_req_fire & req_we;
  end

  assign w_pend       = r_rd_pend_p1 | r_wr_pend_p1;
  assign w_push_data  = {r_wr_pend_p1, r_wr_pend_p1 ? {DATA_WIDTH{1'b0}} : sram_dout};
  assign rsp_is_write = w_head[DATA_WIDTH];
  assign rsp_rdata    = w_head[DATA_WIDTH-1:0];
`else
  assign w_pend       = r_rd_pend_p1;
  assign w_push_data  = sram_dout;
  assign rsp_is_write = 1'b0;
  assign rsp_rdata    = w_head;
`endif

  // Slots committed after this edge; rsp_fire implies w_count >= 1, so no underflow.
  assign w_used    = {1'b0, w_count} + {{CW{1'b0}}, w_pend} - {{CW{1'b0}}, w_rsp_fire};
  assign req_ready = rst_n & (w_used < (CW+1)'(RSP_DEPTH));
  assign rsp_valid = (w_count != '0);

  // Stage p1 -> p2: captured response becomes the registered FIFO head.
  sram22_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_pend),
    .i_push_data (w_push_data),
    .i_pop       (w_rsp_fire),
    .o_count     (w_count),
    .o_head      (w_head)
  );

endmodule

// File: tb/tb_sram22_req_adapter.sv
// Directed bench for sram22_req_adapter with a behavioural 1-cycle-read SRAM22 model.
// Build with SRAM22_WRITE_ACK_EN to exercise the write-ack variant.
module tb_sram22_req_adapter;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int MW = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [MW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_is_write;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  int n_checks = 0;
  int n_fail   = 0;
  logic preload;

  always #5 clk = ~clk;

  sram22_req_adapter #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .WMASK_WIDTH (MW), .RSP_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
    .req_wmask (req_wmask), .req_addr (req_addr), .req_wdata (req_wdata),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .rsp_is_write (rsp_is_write),
    .sram_we (sram_we), .sram_wmask (sram_wmask), .sram_addr (sram_addr),
    .sram_din (sram_din), .sram_dout (sram_dout)
  );

  function automatic logic [DW-1:0] pattern(input int a);
    return 32'hA500_0000 | DW'(a);
  endfunction

  // Behavioural macro: byte-masked write, registered read of the pre-edge contents.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pattern(i);
    end else if (sram_we) begin
      for (int b = 0; b < MW; b++)
        if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
    end
    sram_dout <= mem[sram_addr];
  end

  logic [DW-1:0] rq [$];
  int            rc [$];
  int            cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rsp_valid && rsp_ready) begin
      rq.push_back(rsp_rdata);
      rc.push_back(cyc);
    end
    if (rst_n)
      assert (!(dut.r_rd_pend_p1 && dut.w_count == DEPTH))
        else $error("FAIL fifo_full_with_pend count=%0d", dut.w_count);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives one request and returns 1 ns after the edge where it fired.
  task automatic issue(input logic we, input int addr, input logic [DW-1:0] data,
                       input logic [MW-1:0] mask);
    int w;
    w = 0;
    req_valid = 1'b1; req_we = we; req_addr = AW'(addr);
    req_wdata = data; req_wmask = mask;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk); w++;
    end
    n_checks++;
    if (w >= 50) begin
      $display("FAIL issue_timeout addr=%0d got req_ready=0 want 1", addr); n_fail++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; preload = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'd3; req_wdata = 32'h0BAD_0BAD; req_wmask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b0 || sram_we !== 1'b0 || rsp_valid !== 1'b0) begin
        $display("FAIL reset_outputs got ready=%b we=%b rvalid=%b want 0 0 0",
                 req_ready, sram_we, rsp_valid); n_fail++;
      end
      @(posedge clk); #1;
    end
    preload = 1'b0; req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL reset_release_ready got %b want 1", req_ready); n_fail++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    idle(3);
    issue(1'b1, 5, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 5, '0, 4'h0);
    @(negedge clk);
    n_checks++;
`ifdef SRAM22_WRITE_ACK_EN
    if (rsp_valid !== 1'b1 || rsp_is_write !== 1'b1) begin
      $display("FAIL wr_ack_before_read got v=%b w=%b want 1 1", rsp_valid, rsp_is_write); n_fail++;
    end
`else
    if (rsp_valid !== 1'b0) begin
      $display("FAIL read_latency_early got rsp_valid=%b want 0", rsp_valid); n_fail++;
    end
`endif
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_is_write !== 1'b0) begin
      $display("FAIL write_read got v=%b d=%h w=%b want 1 deadbeef 0",
               rsp_valid, rsp_rdata, rsp_is_write); n_fail++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_mask();
    idle(3);
    issue(1'b1, 7, 32'h1122_3344, 4'hF);
    issue(1'b1, 7, 32'hAABB_CCDD, 4'b0101);
    issue(1'b0, 7, '0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_is_write !== 1'b0 || rsp_rdata !== 32'h11BB_33DD) begin
      $display("FAIL byte_mask got v=%b d=%h want 1 11bb33dd", rsp_valid, rsp_rdata); n_fail++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int idx, base, w;
    logic fired;
    idle(3);
    base = rq.size();
    idx = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(10 + idx);
      @(negedge clk);
      fired = req_ready;
      @(posedge clk); #1;
      if (fired) idx++;
    end
    @(negedge clk);
    n_checks++;
    if (idx !== 2) begin
      $display("FAIL bp_accepted got %0d want 2", idx); n_fail++;
    end
    n_checks++;
    if (req_ready !== 1'b0) begin
      $display("FAIL bp_ready_low got %b want 0", req_ready); n_fail++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== pattern(10)) begin
      $display("FAIL bp_head_hold got v=%b d=%h want 1 %h", rsp_valid, rsp_rdata, pattern(10)); n_fail++;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    w = 0;
    while (idx < 4 && w < 30) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(10 + idx);
      @(negedge clk);
      fired = req_ready;
      @(posedge clk); #1;
      if (fired) idx++;
      w++;
    end
    req_valid = 1'b0;
    w = 0;
    while (rq.size() - base < 4 && w < 30) begin
      @(negedge clk); w++;
    end
    n_checks++;
    if (rq.size() - base != 4) begin
      $display("FAIL bp_rsp_count got %0d want 4", rq.size() - base); n_fail++;
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rq[base+k] !== pattern(10 + k)) begin
          $display("FAIL bp_order[%0d] got %h want %h", k, rq[base+k], pattern(10 + k)); n_fail++;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_throughput();
    int base, w;
    logic [DW-1:0] exp;
    idle(3);
    rsp_ready = 1'b1;
    base = rq.size();
    for (int i = 0; i < 64; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin
        $display("FAIL tp_ready[%0d] got %b want 1", i, req_ready); n_fail++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    w = 0;
    while (rq.size() - base < 64 && w < 200) begin
      @(negedge clk); w++;
    end
    n_checks++;
    if (rq.size() - base != 64) begin
      $display("FAIL tp_rsp_count got %0d want 64", rq.size() - base); n_fail++;
    end else begin
      for (int i = 0; i < 64; i++) begin
        exp = (i == 5) ? 32'hDEAD_BEEF : (i == 7) ? 32'h11BB_33DD : pattern(i);
        n_checks++;
        if (rq[base+i] !== exp) begin
          $display("FAIL tp_data[%0d] got %h want %h", i, rq[base+i], exp); n_fail++;
        end
      end
      n_checks++;
      if (rc[base+63] - rc[base] != 63) begin
        $display("FAIL tp_rate got span %0d want 63", rc[base+63] - rc[base]); n_fail++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    int base;
    idle(3);
    base = rq.size();
    issue(1'b0, 20, '0, 4'h0);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin
      $display("FAIL mid_reset_ready got %b want 0", req_ready); n_fail++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        $display("FAIL mid_reset_no_rsp[%0d] got %b want 0", i, rsp_valid); n_fail++;
      end
    end
    n_checks++;
    if (rq.size() != base) begin
      $display("FAIL mid_reset_rsp_count got %0d want %0d", rq.size(), base); n_fail++;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(1'b1, 30, 32'h1234_5678, 4'hF);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
`ifdef SRAM22_WRITE_ACK_EN
    if (rsp_valid !== 1'b1 || rsp_is_write !== 1'b1 || rsp_rdata !== '0) begin
      $display("FAIL write_ack got v=%b w=%b d=%h want 1 1 0", rsp_valid, rsp_is_write, rsp_rdata); n_fail++;
    end
`else
    if (rsp_valid !== 1'b0 || rsp_is_write !== 1'b0) begin
      $display("FAIL write_no_rsp got v=%b w=%b want 0 0", rsp_valid, rsp_is_write); n_fail++;
    end
`endif
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    #1;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_backpressure();
    test_throughput();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
